// File: rtl/exc_pkg.sv
// ---------------------------------------------------------------------------
// Package: exc_pkg
// Purpose: shared definitions for the trap sequencer. The core and the debug
//          wrapper use the cause codes too, for cause display.
// Contents:
//   CAUSE_*      3-bit trap cause codes (0 = no trap)
//   S_*          2-bit FSM state encoding of exception_controller
//   exc_flags_t  packed bundle of the core's fault flags
//   prio_cause   fixed-priority encoder from flags to a cause code
// ---------------------------------------------------------------------------
package exc_pkg;

  localparam logic [2:0] CAUSE_NONE   = 3'd0;
  localparam logic [2:0] CAUSE_INV    = 3'd1;
  localparam logic [2:0] CAUSE_RDERR  = 3'd2;
  localparam logic [2:0] CAUSE_WRERR  = 3'd3;
  localparam logic [2:0] CAUSE_OOB    = 3'd4;
  localparam logic [2:0] CAUSE_BRFAIL = 3'd5;
  localparam logic [2:0] CAUSE_IRQ    = 3'd6;

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_TRAP    = 2'd1;
  localparam logic [1:0] S_HANDLER = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  typedef struct packed {
    logic invalid;
    logic readerror;
    logic writeerror;
    logic outofbound;
    logic branchFail;
  } exc_flags_t;

  // Lower cause code wins; the interrupt is not handled here because it
  // also depends on the FSM state and the pending latch.
  function automatic logic [2:0] prio_cause(input exc_flags_t f);
    logic [2:0] c;
    c = CAUSE_NONE;
    if (f.invalid)         c = CAUSE_INV;
    else if (f.readerror)  c = CAUSE_RDERR;
    else if (f.writeerror) c = CAUSE_WRERR;
    else if (f.outofbound) c = CAUSE_OOB;
    else if (f.branchFail) c = CAUSE_BRFAIL;
    return c;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// Module: sync_edge_detect
// Purpose: brings an asynchronous level into the clk domain through a chain
//          of SYNC_STAGES flops and emits a one-cycle pulse on each rising
//          edge of the synchronised level.
// Ports:
//   clk      in  core clock, rising edge
//   reset    in  synchronous, active-low; clears the whole chain
//   async_i  in  asynchronous level input
//   rise_o   out one-cycle pulse per rising edge of async_i
// ---------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw input through the synchroniser chain and keep one extra
  // flop of history on the synchronised output for the edge compare.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Pulse when the synchronised level is high but was low a cycle ago.
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/exception_controller.sv
// ---------------------------------------------------------------------------
// Module: exception_controller
// Purpose: trap sequencer for the single-cycle core. Prioritises the fault
//          flags and the VIO override interrupt, latches cause and EPC,
//          stalls the core, redirects it to a per-cause handler vector,
//          returns on eret and halts on a fault inside a handler.
// Ports:
//   clk, reset        core clock; synchronous active-low reset
//   invalid .. branch_fail  fault flags, level, valid in the current cycle
//   override          asynchronous interrupt request, rising edge = request
//   pcactual          PC of the instruction in the current cycle
//   eret              return-from-handler strobe
//   stall             freeze core PC and register-file writes
//   pc_redirect       core loads redirect_pc this cycle
//   redirect_pc       redirect target, zero when pc_redirect is low
//   cause / epc       latched trap cause and trapping PC
//   in_handler        handler running, interrupts masked
//   halted            double fault, sticky until reset
//   irq_ack           one-cycle pulse when the interrupt is taken
//   trap_count        saturating count of traps taken
// ---------------------------------------------------------------------------
module exception_controller
  import exc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] HANDLER_BASE = 'h0000_0100,
  parameter int                CNT_W        = 8,
  parameter int                SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              invalid,
  input  logic              readerror,
  input  logic              writeerror,
  input  logic              outofboundaccess,
  input  logic              branch_fail,
  input  logic              override,
  input  logic [ADDR_W-1:0] pcactual,
  input  logic              eret,
  output logic              stall,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [2:0]        cause,
  output logic [ADDR_W-1:0] epc,
  output logic              in_handler,
  output logic              halted,
  output logic              irq_ack,
  output logic [CNT_W-1:0]  trap_count
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              stall_q, stall_d;
  logic              in_handler_q, in_handler_d;
  logic              halted_q, halted_d;
  logic              irq_ack_q, irq_ack_d;
  logic              irq_pend_q, irq_pend_d;
  logic [CNT_W-1:0]  trap_count_q, trap_count_d;

  logic              irqEdge;
  exc_flags_t        flags;
  logic              anyFlag;
  logic [2:0]        flagCause;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_override_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(override),
    .rise_o (irqEdge)
  );

  assign flags     = {invalid, readerror, writeerror, outofboundaccess, branch_fail};
  assign anyFlag   = |flags;
  assign flagCause = prio_cause(flags);

  // Next-state logic. A fault flag always beats a pending interrupt in RUN;
  // the interrupt stays pending until it is actually taken, and new edges
  // while it is pending simply merge into the same request.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    epc_d        = epc_q;
    stall_d      = stall_q;
    in_handler_d = in_handler_q;
    halted_d     = halted_q;
    irq_ack_d    = 1'b0;
    irq_pend_d   = irq_pend_q | irqEdge;
    trap_count_d = trap_count_q;

    case (state_q)
      S_RUN: begin
        if (anyFlag || irq_pend_q) begin
          if (anyFlag) begin
            cause_d = flagCause;
          end else begin
            cause_d    = CAUSE_IRQ;
            irq_ack_d  = 1'b1;
            irq_pend_d = irqEdge;
          end
          epc_d   = pcactual;
          stall_d = 1'b1;
          state_d = S_TRAP;
          if (trap_count_q != {CNT_W{1'b1}}) begin
            trap_count_d = trap_count_q + 1'b1;
          end
        end
      end
      S_TRAP: begin
        stall_d      = 1'b0;
        in_handler_d = 1'b1;
        state_d      = S_HANDLER;
      end
      S_HANDLER: begin
        // A fault inside the handler is fatal even if eret arrives with it.
        if (anyFlag) begin
          stall_d      = 1'b1;
          halted_d     = 1'b1;
          in_handler_d = 1'b0;
          state_d      = S_HALT;
        end else if (eret) begin
          in_handler_d = 1'b0;
          cause_d      = CAUSE_NONE;
          state_d      = S_RUN;
        end
      end
      S_HALT: begin
        irq_pend_d = irq_pend_q;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Redirect decode. The handler vector is presented during TRAP; the return
  // target is presented in the eret cycle so the core loads it on the same
  // edge that moves the FSM back to RUN. Interrupts resume at the interrupted
  // instruction, faults skip past the faulting one.
  always_comb begin
    pc_redirect = 1'b0;
    redirect_pc = '0;
    if (state_q == S_TRAP) begin
      pc_redirect = 1'b1;
      redirect_pc = HANDLER_BASE + ADDR_W'({cause_q, 2'b00});
    end else if (state_q == S_HANDLER && eret && !anyFlag) begin
      pc_redirect = 1'b1;
      redirect_pc = (cause_q == CAUSE_IRQ) ? epc_q : epc_q + ADDR_W'(4);
    end
  end

  // State and output registers. Reset wins over every state, HALT included.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_RUN;
      cause_q      <= CAUSE_NONE;
      epc_q        <= '0;
      stall_q      <= 1'b0;
      in_handler_q <= 1'b0;
      halted_q     <= 1'b0;
      irq_ack_q    <= 1'b0;
      irq_pend_q   <= 1'b0;
      trap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      epc_q        <= epc_d;
      stall_q      <= stall_d;
      in_handler_q <= in_handler_d;
      halted_q     <= halted_d;
      irq_ack_q    <= irq_ack_d;
      irq_pend_q   <= irq_pend_d;
      trap_count_q <= trap_count_d;
    end
  end

  assign stall      = stall_q;
  assign cause      = cause_q;
  assign epc        = epc_q;
  assign in_handler = in_handler_q;
  assign halted     = halted_q;
  assign irq_ack    = irq_ack_q;
  assign trap_count = trap_count_q;

endmodule
